frame_draw_sequencer: RTL and testbench
=======================================

Name: frame_draw_sequencer

Overview:
- Sequences every pixel write into the vga_adapter write port (x, y, colour, plot) once per game frame.
- On each accepted frame tick it repaints the full scrolled background from the background ROM, then overlays the car sprite from the sprite ROM.
- Owns the vertical scroll offset, so the scroll is applied at the ROM-address stage rather than by bending the adapter's y coordinate.
- Sits between the speed/tick logic and vga_adapter.

Parameters:
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- SCROLL_SPEED, 1, rows advanced per scrolled frame; must be less than YSCREEN
- SPR_W, 8, car sprite width
- SPR_H, 16, car sprite height
- TRANSP, 3'b000, sprite colour treated as transparent

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse requesting a frame redraw
- scroll_en  in  1  sampled with an accepted tick; 1 = advance the scroll offset
- car_x  in  8  sprite left column, sampled with an accepted tick
- car_y  in  7  sprite top row, sampled with an accepted tick
- bg_addr  out  15  background ROM address = row*XSCREEN + col
- bg_data  in  3  background ROM data, registered ROM, valid 1 cycle after address
- spr_addr  out  7  sprite ROM address = sy*SPR_W + sx
- spr_data  in  3  sprite ROM data, valid 1 cycle after address
- VGA_X  out  8  pixel x to vga_adapter
- VGA_Y  out  7  pixel y to vga_adapter
- VGA_COLOR  out  3  pixel colour to vga_adapter
- plot  out  1  write strobe to vga_adapter
- busy  out  1  high while a frame is being drawn
- done  out  1  one-cycle pulse when a frame completes
- missed  out  8  saturating count of dropped frame ticks

Behaviour:
Reset:
- Asynchronous; forces state IDLE.
- Clears the scroll offset, the x/y counters, missed, all VGA_* outputs, plot, busy and done.
- Applies equally mid-frame; no partial-frame completion afterwards.

States IDLE -> BG -> CAR -> FLUSH -> DONE -> IDLE.
- IDLE:
  - A frame_tick is accepted here (cycle 0).
  - Latch car_x and car_y.
  - If scroll_en, offset <= (offset + SCROLL_SPEED) mod YSCREEN. The wrap is exact: the offset never reaches YSCREEN.
  - Go to BG. busy rises in cycle 1.
- BG:
  - Raster scan x 0..XSCREEN-1 inner, y 0..YSCREEN-1 outer; one pixel per cycle; 19200 cycles.
  - bg_addr = ((y + YSCREEN - offset) mod YSCREEN)*XSCREEN + x, so the image moves down as the offset grows.
- CAR:
  - Scan sx 0..SPR_W-1 inner, sy 0..SPR_H-1 outer; 128 cycles.
  - Screen pixel is (car_x+sx, car_y+sy).
- FLUSH: one cycle draining the ROM pipeline.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Total cycles from the accepting cycle to done: 1 + 19200 + 128 + 1 = 19330 (done in cycle 19330).

Pipeline:
- The address for a pixel is presented in cycle n.
- VGA_X, VGA_Y and plot for that pixel are registered and valid in cycle n+1.
- VGA_COLOR = the ROM data in cycle n+1; it is 0 when plot is 0.

Plot rules:
- BG: plot = 1 for every pixel.
- CAR: plot = 0 when spr_data == TRANSP.
- CAR: plot = 0 when car_x+sx >= XSCREEN or car_y+sy >= YSCREEN (clip, no wrap). The cycle is still consumed.
- Sum width: 9-bit x sum, 8-bit y sum.

frame_tick while busy:
- Dropped (default build).
- missed increments and saturates at 255.
- Latched car_x, car_y and offset are unaffected.

Optional Feature:
PENDING_TICK_EN
- Defined: one frame_tick arriving while busy is held pending. The frame after DONE starts immediately in the next IDLE cycle, sampling car_x, car_y and scroll_en in that cycle. Only a second tick while one is already pending increments missed.
- Undefined: every tick while busy is dropped and counted.

Test Plan:
1. reset, then frame_tick with scroll_en=0, car (76,100), all-opaque sprite:
   - First plot at (0,0) with bg_addr 0 issued in cycle 1.
   - Last background plot at (159,119) from bg_addr 19199.
   - Sprite pixels cover x 76..83, y 100..115.
   - done in cycle 19330; busy is high in cycles 1..19329.
2. Scroll offset 1: screen row 0 reads ROM row 119 (first bg_addr 19040). Repeat for offset 119: first bg_addr 160. After 120 ticks at SCROLL_SPEED=1, offset returns to 0.
3. car (156,110): plot only for x 156..159 and y 110..119; 4x10 = 40 sprite plots out of 128 cycles; done still in cycle 19330.
4. Sprite with TRANSP at sx=0 in all rows: no plot in column car_x during CAR; background colour at that column is untouched.
5. Three frame_ticks during busy:
   - Default build: missed = 3 and no extra frame.
   - PENDING_TICK_EN: missed = 2 and a second frame starts the cycle after done.
6. Assert reset at pixel 5000 of BG: all outputs are 0 and state is IDLE immediately. A fresh tick then restarts at (0,0) with offset 0.

Source files
------------

// File: rtl/frame_draw_sequencer.sv
// Per-frame pixel sequencer for vga_adapter: scrolled background repaint, then car sprite overlay.
// Optional build macro PENDING_TICK_EN: hold one frame_tick that arrives while busy and start it after DONE.
//
// state   | meaning
// IDLE    | waiting for frame_tick (or a held tick); latches car position and steps scroll
// BG      | raster-scan full screen from background ROM, one pixel per cycle
// CAR     | scan sprite window, clipped at screen edge, transparent colour skipped
// FLUSH   | last sprite read drains out of the ROM pipeline
// DONE    | one-cycle done pulse, back to IDLE
module frame_draw_sequencer #(
    parameter int         XSCREEN      = 160,
    parameter int         YSCREEN      = 120,
    parameter int         SCROLL_SPEED = 1,
    parameter int         SPR_W        = 8,
    parameter int         SPR_H        = 16,
    parameter logic [2:0] TRANSP       = 3'b000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        scroll_en,
    input  logic [7:0]  car_x,
    input  logic [6:0]  car_y,
    output logic [14:0] bg_addr,
    input  logic [2:0]  bg_data,
    output logic [6:0]  spr_addr,
    input  logic [2:0]  spr_data,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic [2:0]  VGA_COLOR,
    output logic        plot,
    output logic        busy,
    output logic        done,
    output logic [7:0]  missed
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BG    = 3'd1;
    localparam logic [2:0] S_CAR   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] state;
    logic [7:0] x_cnt;
    logic [6:0] y_cnt;
    logic [6:0] offset;
    logic [7:0] car_x_q;
    logic [6:0] car_y_q;
    logic       pix_plot;
    logic       pix_spr;

    logic       start;
    logic       tick_lost;
    logic       x_last;
    logic       y_last;
    logic [7:0] row_sum;
    logic [7:0] row;
    logic [7:0] off_sum;
    logic [6:0] off_next;
    logic [8:0] scr_x;
    logic [7:0] scr_y;
    logic       in_screen;

    // Scroll is applied on the ROM row, so screen row y shows ROM row (y - offset) wrapped.
    always_comb begin
        row_sum = 8'(y_cnt) + 8'(YSCREEN) - 8'(offset);
        row     = (row_sum >= 8'(YSCREEN)) ? row_sum - 8'(YSCREEN) : row_sum;
        bg_addr = 15'(row) * 15'(XSCREEN) + 15'(x_cnt);
        spr_addr = 7'(y_cnt) * 7'(SPR_W) + 7'(x_cnt);
        off_sum  = 8'(offset) + 8'(SCROLL_SPEED);
        off_next = (off_sum >= 8'(YSCREEN)) ? 7'(off_sum - 8'(YSCREEN)) : 7'(off_sum);
        scr_x     = 9'(car_x_q) + 9'(x_cnt);
        scr_y     = 8'(car_y_q) + 8'(y_cnt);
        in_screen = (scr_x < 9'(XSCREEN)) && (scr_y < 8'(YSCREEN));
        x_last = (state == S_BG) ? (x_cnt == 8'(XSCREEN - 1)) : (x_cnt == 8'(SPR_W - 1));
        y_last = (state == S_BG) ? (y_cnt == 7'(YSCREEN - 1)) : (y_cnt == 7'(SPR_H - 1));
    end

`ifdef PENDING_TICK_EN
    logic pending;

    always_comb begin
        start     = (state == S_IDLE) && (frame_tick || pending);
        tick_lost = frame_tick && (state != S_IDLE) && pending;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (start) begin
            pending <= 1'b0;
        end else if (frame_tick && (state != S_IDLE)) begin
            pending <= 1'b1;
        end
    end
`else
    always_comb begin
        start     = (state == S_IDLE) && frame_tick;
        tick_lost = frame_tick && (state != S_IDLE);
    end
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            offset   <= '0;
            car_x_q  <= '0;
            car_y_q  <= '0;
            pix_plot <= 1'b0;
            pix_spr  <= 1'b0;
            VGA_X    <= '0;
            VGA_Y    <= '0;
            missed   <= '0;
        end else begin
            pix_plot <= 1'b0;
            pix_spr  <= 1'b0;
            if (tick_lost && (missed != 8'hFF)) begin
                missed <= missed + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        car_x_q <= car_x;
                        car_y_q <= car_y;
                        if (scroll_en) begin
                            offset <= off_next;
                        end
                        x_cnt <= '0;
                        y_cnt <= '0;
                        state <= S_BG;
                    end
                end
                S_BG, S_CAR: begin
                    pix_plot <= (state == S_BG) ? 1'b1 : in_screen;
                    pix_spr  <= (state == S_CAR);
                    VGA_X    <= (state == S_BG) ? x_cnt : scr_x[7:0];
                    VGA_Y    <= (state == S_BG) ? y_cnt : scr_y[6:0];
                    if (x_last) begin
                        x_cnt <= '0;
                        if (y_last) begin
                            y_cnt <= '0;
                            state <= (state == S_BG) ? S_CAR : S_FLUSH;
                        end else begin
                            y_cnt <= y_cnt + 7'd1;
                        end
                    end else begin
                        x_cnt <= x_cnt + 8'd1;
                    end
                end
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sprite transparency is only known once the ROM word arrives, so it gates plot here.
    always_comb begin
        busy      = (state == S_BG) || (state == S_CAR) || (state == S_FLUSH);
        done      = (state == S_DONE);
        plot      = pix_plot && !(pix_spr && (spr_data == TRANSP));
        VGA_COLOR = !plot ? 3'b000 : (pix_spr ? spr_data : bg_data);
    end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Bench for frame_draw_sequencer: random background/sprite ROMs checked against a framebuffer model.
module tb_frame_draw_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        scroll_en;
    logic [7:0]  car_x;
    logic [6:0]  car_y;
    logic [14:0] bg_addr;
    logic [2:0]  bg_data;
    logic [6:0]  spr_addr;
    logic [2:0]  spr_data;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [2:0]  VGA_COLOR;
    logic        plot;
    logic        busy;
    logic        done;
    logic [7:0]  missed;

    // Small-screen instance so the full scroll wrap fits in a short run.
    logic        frame_tick_s;
    logic        scroll_en_s;
    logic [7:0]  car_x_s;
    logic [6:0]  car_y_s;
    logic [14:0] bg_addr_s;
    logic [2:0]  bg_data_s;
    logic [6:0]  spr_addr_s;
    logic [2:0]  spr_data_s;
    logic [7:0]  vga_x_s;
    logic [6:0]  vga_y_s;
    logic [2:0]  vga_color_s;
    logic        plot_s;
    logic        busy_s;
    logic        done_s;
    logic [7:0]  missed_s;

    always #5 CLOCK_50 = ~CLOCK_50;

    frame_draw_sequencer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick), .scroll_en(scroll_en),
        .car_x(car_x), .car_y(car_y), .bg_addr(bg_addr), .bg_data(bg_data),
        .spr_addr(spr_addr), .spr_data(spr_data), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
        .VGA_COLOR(VGA_COLOR), .plot(plot), .busy(busy), .done(done), .missed(missed)
    );

    frame_draw_sequencer #(.XSCREEN(16), .YSCREEN(12), .SCROLL_SPEED(1)) dut_s (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick_s), .scroll_en(scroll_en_s),
        .car_x(car_x_s), .car_y(car_y_s), .bg_addr(bg_addr_s), .bg_data(bg_data_s),
        .spr_addr(spr_addr_s), .spr_data(spr_data_s), .VGA_X(vga_x_s), .VGA_Y(vga_y_s),
        .VGA_COLOR(vga_color_s), .plot(plot_s), .busy(busy_s), .done(done_s), .missed(missed_s)
    );

    logic [2:0] bg_mem  [0:19199];
    logic [2:0] spr_mem [0:127];
    logic [3:0] obs_fb  [0:19199];
    logic [2:0] exp_fb  [0:19199];

    always @(posedge CLOCK_50) begin
        bg_data  <= (bg_addr < 15'd19200) ? bg_mem[bg_addr] : 3'd0;
        spr_data <= spr_mem[spr_addr];
    end

    int vectors    = 0;
    int miscompares = 0;
    int tb_off     = 0;
    int missed_exp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: no ticks while busy; 1: three ticks; 2: a tick every other cycle (saturates missed)
    task automatic run_frame(input string name, input int cx, input int cy, input logic sc,
                             input int mode, output int car_plots);
        int exp_car = 0, bg_plots = 0, order_err = 0, czero_err = 0, oob = 0;
        int busy_err = 0, fb_err = 0, done_cyc = -1, lost = 0, cnt;
        logic busy_at_done = 1'b1;
        logic [2:0] sp;
        car_plots = 0;
        if (sc) tb_off = (tb_off + 1) % 120;
        // Screen row y shows ROM row (y - offset) wrapped; the sprite is painted over it.
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_fb[y*160 + x] = bg_mem[((y + 120 - tb_off) % 120)*160 + x];
        for (int sy = 0; sy < 16; sy++)
            for (int sx = 0; sx < 8; sx++) begin
                sp = spr_mem[sy*8 + sx];
                if (sp != 3'd0 && cx + sx < 160 && cy + sy < 120) begin
                    exp_fb[(cy + sy)*160 + cx + sx] = sp;
                    exp_car++;
                end
            end
        for (int i = 0; i < 19200; i++) obs_fb[i] = 4'hF;

        frame_tick = 1'b1;
        scroll_en  = sc;
        car_x      = 8'(cx);
        car_y      = 7'(cy);
        for (int cyc = 1; cyc <= 19400; cyc++) begin
            @(negedge CLOCK_50);
            if (cyc == 1) check({name, ".first_bg_addr"}, 64'(bg_addr), 64'(((120 - tb_off) % 120)*160));
            if (cyc < 19330 && busy !== 1'b1) busy_err++;
            if (plot === 1'b1) begin
                if (VGA_X < 8'd160 && VGA_Y < 7'd120) obs_fb[int'(VGA_Y)*160 + int'(VGA_X)] = {1'b0, VGA_COLOR};
                else oob++;
                if (cyc >= 2 && cyc <= 19201) bg_plots++;
                else car_plots++;
            end else if (VGA_COLOR !== 3'd0) begin
                czero_err++;
            end
            if (cyc >= 2 && cyc <= 19201)
                if (plot !== 1'b1 || VGA_X !== 8'((cyc - 2) % 160) || VGA_Y !== 7'((cyc - 2) / 160))
                    order_err++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                busy_at_done = busy;
                break;
            end
            frame_tick = 1'b0;
            car_x = 8'($urandom);
            car_y = 7'($urandom);
            scroll_en = (cyc < 19000) ? 1'($urandom) : 1'b0;
            if ((mode == 1 && (cyc == 100 || cyc == 7000 || cyc == 19250)) ||
                (mode == 2 && cyc >= 10 && cyc <= 800 && cyc % 2 == 0)) begin
                frame_tick = 1'b1;
                lost++;
            end
        end
        frame_tick = 1'b0;
        scroll_en  = 1'b0;
`ifdef PENDING_TICK_EN
        if (lost > 0) missed_exp += lost - 1;
`else
        missed_exp += lost;
`endif
        if (missed_exp > 255) missed_exp = 255;
        for (int i = 0; i < 19200; i++)
            if (obs_fb[i] !== {1'b0, exp_fb[i]}) fb_err++;

        check({name, ".done_cycle"}, 64'(done_cyc), 64'(19330));
        check({name, ".busy_at_done"}, 64'(busy_at_done), 64'(0));
        check({name, ".busy_gaps"}, 64'(busy_err), 64'(0));
        check({name, ".bg_plots"}, 64'(bg_plots), 64'(19200));
        check({name, ".car_plots"}, 64'(car_plots), 64'(exp_car));
        check({name, ".raster_order"}, 64'(order_err), 64'(0));
        check({name, ".colour_when_idle"}, 64'(czero_err), 64'(0));
        check({name, ".off_screen"}, 64'(oob), 64'(0));
        check({name, ".framebuffer"}, 64'(fb_err), 64'(0));
        check({name, ".missed"}, 64'(missed), 64'(missed_exp));

        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
`ifdef PENDING_TICK_EN
        check({name, ".busy_after_done"}, 64'(busy), 64'(lost > 0 ? 1 : 0));
        if (lost > 0) begin
            cnt = 1;
            while (done !== 1'b1 && cnt < 19400) begin
                @(negedge CLOCK_50);
                cnt++;
            end
            check({name, ".pending_done_cycle"}, 64'(cnt), 64'(19330));
            @(negedge CLOCK_50);
        end
`else
        check({name, ".no_extra_frame"}, 64'({busy, done}), 64'(0));
`endif
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cp, bad, cnt, off_s, cx, cy;
        reset = 1'b1;
        frame_tick = 1'b0; scroll_en = 1'b0; car_x = '0; car_y = '0;
        frame_tick_s = 1'b0; scroll_en_s = 1'b0; car_x_s = '0; car_y_s = '0;
        bg_data_s = 3'd0; spr_data_s = 3'd0;
        for (int i = 0; i < 19200; i++) bg_mem[i] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 128; i++) spr_mem[i] = 3'($urandom_range(1, 7));
        repeat (3) @(negedge CLOCK_50);
        check("reset_outputs", 64'({VGA_X, VGA_Y, VGA_COLOR, plot, busy, done, missed, bg_addr, spr_addr}), 64'(0));
        reset = 1'b0;
        @(negedge CLOCK_50);

        run_frame("opaque_76_100", 76, 100, 1'b0, 0, cp);
        check("opaque_76_100.sprite_plots", 64'(cp), 64'(128));

        for (int i = 0; i < 128; i++) spr_mem[i] = 3'($urandom_range(1, 7));
        run_frame("clip_scroll1", 156, 110, 1'b1, 1, cp);
        check("clip_scroll1.sprite_plots", 64'(cp), 64'(40));

        // Column 0 transparent, rest random (including more transparent pixels).
        for (int i = 0; i < 128; i++) spr_mem[i] = (i % 8 == 0) ? 3'd0 : 3'($urandom_range(0, 7));
        frame_tick = 1'b1; scroll_en = 1'b1; car_x = 8'd20; car_y = 7'd20;
        for (int cyc = 1; cyc <= 5001; cyc++) begin
            @(negedge CLOCK_50);
            frame_tick = 1'b0;
            scroll_en  = 1'b0;
        end
        check("pre_reset_pixel", 64'({plot, VGA_X, VGA_Y}), 64'({1'b1, 8'd39, 7'd31}));
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'({VGA_X, VGA_Y, VGA_COLOR, plot, busy, done, missed, bg_addr, spr_addr}), 64'(0));
        tb_off = 0;
        missed_exp = 0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge CLOCK_50);
            if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0) bad++;
        end
        check("no_partial_frame", 64'(bad), 64'(0));
        cx = $urandom_range(0, 159);
        cy = $urandom_range(0, 119);
        run_frame("restart_transp", cx, cy, 1'b0, 2, cp);

        off_s = 0;
        for (int k = 1; k <= 12; k++) begin
            off_s = (off_s + 1) % 12;
            frame_tick_s = 1'b1;
            scroll_en_s  = 1'b1;
            cnt = 0;
            for (int cyc = 1; cyc <= 400; cyc++) begin
                @(negedge CLOCK_50);
                if (cyc == 1) check($sformatf("small_first_bg_addr_%0d", k), 64'(bg_addr_s), 64'(((12 - off_s) % 12)*16));
                frame_tick_s = 1'b0;
                scroll_en_s  = 1'b0;
                if (done_s === 1'b1) begin
                    cnt = cyc;
                    break;
                end
            end
            check($sformatf("small_done_cycle_%0d", k), 64'(cnt), 64'(322));
            @(negedge CLOCK_50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
